// File: rtl/led_mode_controller.sv
// led_mode_controller: synchronizes and debounces the south push-button and steps the LED
// through OFF / ON / BLINK / DIM. Define LED_DIM_EN to build the PWM DIM mode in.
module led_mode_controller #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_CYCLES = 12500000,
  parameter int PWM_BITS          = 8,
  parameter int DIM_DUTY          = 32
) (
  input  logic       CLK_50MHZ,
  input  logic       RESET_N,
  input  logic       BUTTON_SOUTH,
  output logic       led,
  output logic [1:0] mode,
  output logic       press
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int BCNT_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_DIM   = 2'd3
  } mode_e;

  logic              s1, s2;
  logic              stable, stable_d;
  logic [DCNT_W-1:0] dcnt;
  logic              press_next;
  mode_e             mode_q, mode_next;
  logic [BCNT_W-1:0] bcnt, bcnt_next;
  logic              phase, phase_next;
  logic              led_next;
  logic              dim_on;

  // NOTE: sequential state is always assigned with non-blocking (<=) so every flop
  // samples the values that existed before the clock edge.
  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BUTTON_SOUTH;
      s2 <= s1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      dcnt     <= '0;
    end else begin
      stable_d <= stable;
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_LAST) begin
        stable <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign press_next = stable & ~stable_d;

`ifdef LED_DIM_EN
  localparam logic [PWM_BITS-1:0] DUTY = PWM_BITS'(DIM_DUTY);
  logic [PWM_BITS-1:0] pcnt;

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) pcnt <= '0;
    else          pcnt <= pcnt + 1'b1;
  end

  assign dim_on = (pcnt < DUTY);
`else
  logic unused_dim_cfg;
  assign unused_dim_cfg = ^{PWM_BITS, DIM_DUTY};
  assign dim_on         = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mode_next  = mode_q;
    bcnt_next  = '0;
    phase_next = 1'b0;
    led_next   = 1'b0;

    if (press_next) begin
      unique case (mode_q)
        MODE_OFF:   mode_next = MODE_ON;
        MODE_ON:    mode_next = MODE_BLINK;
`ifdef LED_DIM_EN
        MODE_BLINK: mode_next = MODE_DIM;
`else
        MODE_BLINK: mode_next = MODE_OFF;
`endif
        MODE_DIM:   mode_next = MODE_OFF;
      endcase
    end

    // Entering BLINK starts a lit half-period; leaving it parks the counter at zero.
    if (mode_next == MODE_BLINK) begin
      if (mode_q != MODE_BLINK) begin
        phase_next = 1'b1;
      end else if (bcnt == BCNT_LAST) begin
        phase_next = ~phase;
      end else begin
        bcnt_next  = bcnt + 1'b1;
        phase_next = phase;
      end
    end

    unique case (mode_q)
      MODE_OFF:   led_next = 1'b0;
      MODE_ON:    led_next = 1'b1;
      MODE_BLINK: led_next = phase;
      MODE_DIM:   led_next = dim_on;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= MODE_OFF;
      bcnt   <= '0;
      phase  <= 1'b0;
      led    <= 1'b0;
      press  <= 1'b0;
    end else begin
      mode_q <= mode_next;
      bcnt   <= bcnt_next;
      phase  <= phase_next;
      led    <= led_next;
      press  <= press_next;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Testbench for led_mode_controller: directed button stimulus, press/mode scoreboard and
// per-cycle LED checks. Follows LED_DIM_EN the same way the design does.
module tb_led_mode_controller;

  localparam int DEB  = 4;
  localparam int BH   = 3;
  localparam int PB   = 3;
  localparam int DUTY = 2;
  localparam int LAT  = DEB + 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn   = 1'b0;
  logic       led;
  logic       press;
  logic [1:0] mode;

  int         cyc      = 0;
  int         checks   = 0;
  int         errors   = 0;
  int         rel_edge = 0;
  logic [1:0] exp_mode = 2'd0;

  typedef struct {
    int         edge_no;
    logic [1:0] mode;
  } press_t;

  press_t sb[$];

  led_mode_controller #(
    .DEBOUNCE_CYCLES  (DEB),
    .BLINK_HALF_CYCLES(BH),
    .PWM_BITS         (PB),
    .DIM_DUTY         (DUTY)
  ) dut (
    .CLK_50MHZ   (clk),
    .RESET_N     (rst_n),
    .BUTTON_SOUTH(btn),
    .led         (led),
    .mode        (mode),
    .press       (press)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every press pulse must match the oldest expected press in edge and mode.
  always @(negedge clk) begin
    if (press === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL press_spurious at cycle %0d: got press with mode %0d, expected no press",
                 cyc, mode);
      end else begin
        press_t e;
        e = sb.pop_front();
        check("press_edge", cyc, e.edge_no);
        check("press_mode", mode, e.mode);
      end
    end
  end

  function automatic logic [1:0] next_mode(input logic [1:0] m);
`ifdef LED_DIM_EN
    return m + 2'd1;
`else
    return (m == 2'd2) ? 2'd0 : m + 2'd1;
`endif
  endfunction

  function automatic logic exp_led(input logic [1:0] m, input int enter, input int j);
    case (m)
      2'd1:    return 1'b1;
      2'd2:    return (((j - enter - 1) / BH) % 2) == 0;
      2'd3:    return ((j - 1 - rel_edge) % (1 << PB)) < DUTY;
      default: return 1'b0;
    endcase
  endfunction

  task automatic goto(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge: raises the button and expects the accepted press LAT edges later.
  task automatic press_and_watch(input bit release_after, input int window);
    int e;
    btn      = 1'b1;
    exp_mode = next_mode(exp_mode);
    e        = cyc + LAT;
    sb.push_back('{e, exp_mode});
    for (int j = e + 1; j <= e + window; j++) begin
      goto(j);
      if (j == e + 1) check("press_seen", sb.size(), 0);
      check("mode", mode, exp_mode);
      check("led", led, exp_led(exp_mode, e, j));
    end
    if (release_after) begin
      btn = 1'b0;
      idle(DEB + 6);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;

    // Reset held with a toggling button.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn = ~btn;
      check("rst_led", led, 0);
      check("rst_mode", mode, 0);
      check("rst_press", press, 0);
    end
    btn = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rel_edge = cyc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_led", led, 0);
      check("idle_mode", mode, 0);
    end

    // Clean press, then release.
    press_and_watch(1'b1, 16);

    // Bounce: two DEB-1 cycle high pulses never reach acceptance.
    btn = 1'b1; idle(DEB - 1);
    btn = 1'b0; idle(1);
    btn = 1'b1; idle(DEB - 1);
    btn = 1'b0; idle(DEB + 6);
    check("bounce_mode", mode, exp_mode);
    check("bounce_led", led, 1);

    // Remaining presses of the full mode cycle.
    for (int p = 0; p < 3; p++) press_and_watch(1'b1, 16);

    // Reach BLINK with the button still held, then reset asynchronously.
    while (next_mode(exp_mode) != 2'd2) press_and_watch(1'b1, 4);
    press_and_watch(1'b0, 5);
    check("sb_pre_reset", sb.size(), 0);
    rst_n    = 1'b0;
    exp_mode = 2'd0;
    #1;
    check("async_rst_mode", mode, 0);
    check("async_rst_led", led, 0);
    check("async_rst_press", press, 0);
    idle(2);
    rst_n    = 1'b1;
    rel_edge = cyc;
    press_and_watch(1'b1, 6);

    idle(DEB + 6);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no end of stimulus, expected finish", cyc);
    $fatal(1);
  end

endmodule
